// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: operation codes and width defaults.
// Imported by alu and alu_compare.
package alu_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_WIDTH = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // True for the ten codes that select a real operation.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_compare.sv
// Combinational operand comparator producing the branch-resolution flags.
module alu_compare
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             eq,
  output logic             ltu,
  output logic             gteu,
  output logic             lts,
  output logic             gtes
);

  assign eq   = (a_data == b_data);
  assign ltu  = (a_data < b_data);
  assign lts  = ($signed(a_data) < $signed(b_data));
  // Greater-or-equal is the exact complement, so each pair is always one-hot.
  assign gteu = ~ltu;
  assign gtes = ~lts;

endmodule

// File: rtl/alu.sv
// RV32I-style integer ALU with registered result and comparison flags (one-cycle latency).
// Optional ALU_ILLEGAL_OP_EN adds a registered illegal_op_w_o_h output.
module alu #(
  parameter int DATA_WIDTH  = alu_pkg::DATA_WIDTH,
  parameter int SHAMT_WIDTH = alu_pkg::SHAMT_WIDTH
) (
  input  logic                  clk_w_i,
  input  logic                  rst_w_i_l,
  input  logic [DATA_WIDTH-1:0] a_data_w_i,
  input  logic [DATA_WIDTH-1:0] b_data_w_i,
  input  logic [3:0]            alu_control_w_i,
  input  logic                  addi_sub_flag_w_i,
  input  logic                  store_force_add_flag_w_i,
  output logic [DATA_WIDTH-1:0] alu_res_w_o,
  output logic                  eq_w_o_h,
  output logic                  gteu_w_o_h,
  output logic                  ltu_w_o_h,
  output logic                  gtes_w_o_h,
  output logic                  lts_w_o_h
`ifdef ALU_ILLEGAL_OP_EN
  ,
  output logic                  illegal_op_w_o_h
`endif
);

  import alu_pkg::*;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  sum;
  logic [DATA_WIDTH-1:0]  diff;
  logic [DATA_WIDTH-1:0]  sll_res;
  logic [DATA_WIDTH-1:0]  srl_res;
  logic [DATA_WIDTH-1:0]  sra_res;
  logic [DATA_WIDTH-1:0]  res_next;
  logic                   eq_next;
  logic                   ltu_next;
  logic                   gteu_next;
  logic                   lts_next;
  logic                   gtes_next;

  logic [DATA_WIDTH-1:0]  res_reg;
  logic                   eq_reg;
  logic                   ltu_reg;
  logic                   gteu_reg;
  logic                   lts_reg;
  logic                   gtes_reg;

  alu_compare #(
    .WIDTH (DATA_WIDTH)
  ) u_compare (
    .a_data (a_data_w_i),
    .b_data (b_data_w_i),
    .eq     (eq_next),
    .ltu    (ltu_next),
    .gteu   (gteu_next),
    .lts    (lts_next),
    .gtes   (gtes_next)
  );

  // Only the low bits of B select the shift distance; upper bits are ignored.
  assign shamt   = b_data_w_i[SHAMT_WIDTH-1:0];
  assign sum     = a_data_w_i + b_data_w_i;
  assign diff    = a_data_w_i - b_data_w_i;
  assign sll_res = a_data_w_i << shamt;
  assign srl_res = a_data_w_i >> shamt;
  assign sra_res = $unsigned($signed(a_data_w_i) >>> shamt);

  always_comb begin
    res_next = '0;
    if (store_force_add_flag_w_i) begin
      // Address generation for loads/stores always adds.
      res_next = sum;
    end else begin
      case (alu_control_w_i)
        ALU_ADD:  res_next = sum;
        ALU_SLL:  res_next = sll_res;
        ALU_SLT:  res_next = {{(DATA_WIDTH-1){1'b0}}, lts_next};
        ALU_SLTU: res_next = {{(DATA_WIDTH-1){1'b0}}, ltu_next};
        ALU_XOR:  res_next = a_data_w_i ^ b_data_w_i;
        ALU_SRL:  res_next = srl_res;
        ALU_OR:   res_next = a_data_w_i | b_data_w_i;
        ALU_AND:  res_next = a_data_w_i & b_data_w_i;
        ALU_SUB:  res_next = addi_sub_flag_w_i ? diff : sum;
        ALU_SRA:  res_next = sra_res;
        default:  res_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_w_i) begin
    if (!rst_w_i_l) begin
      res_reg  <= '0;
      eq_reg   <= 1'b0;
      ltu_reg  <= 1'b0;
      gteu_reg <= 1'b0;
      lts_reg  <= 1'b0;
      gtes_reg <= 1'b0;
    end else begin
      res_reg  <= res_next;
      eq_reg   <= eq_next;
      ltu_reg  <= ltu_next;
      gteu_reg <= gteu_next;
      lts_reg  <= lts_next;
      gtes_reg <= gtes_next;
    end
  end

  assign alu_res_w_o = res_reg;
  assign eq_w_o_h    = eq_reg;
  assign ltu_w_o_h   = ltu_reg;
  assign gteu_w_o_h  = gteu_reg;
  assign lts_w_o_h   = lts_reg;
  assign gtes_w_o_h  = gtes_reg;

`ifdef ALU_ILLEGAL_OP_EN
  logic illegal_next;
  logic illegal_reg;

  assign illegal_next = ~store_force_add_flag_w_i & ~is_legal_op(alu_control_w_i);

  always_ff @(posedge clk_w_i) begin
    if (!rst_w_i_l) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= illegal_next;
    end
  end

  assign illegal_op_w_o_h = illegal_reg;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at drive time, compared one cycle later.
module tb_alu;

  logic        clk;
  logic        rst_l;
  logic [31:0] a_data;
  logic [31:0] b_data;
  logic [3:0]  ctl;
  logic        sub_flag;
  logic        force_add;
  logic [31:0] res;
  logic        eq, gteu, ltu, gtes, lts;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  logic in_valid = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  flg;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  alu dut (
    .clk_w_i                  (clk),
    .rst_w_i_l                (rst_l),
    .a_data_w_i               (a_data),
    .b_data_w_i               (b_data),
    .alu_control_w_i          (ctl),
    .addi_sub_flag_w_i        (sub_flag),
    .store_force_add_flag_w_i (force_add),
    .alu_res_w_o              (res),
    .eq_w_o_h                 (eq),
    .gteu_w_o_h               (gteu),
    .ltu_w_o_h                (ltu),
    .gtes_w_o_h               (gtes),
    .lts_w_o_h                (lts)
`ifdef ALU_ILLEGAL_OP_EN
    ,
    .illegal_op_w_o_h         (illegal)
`endif
  );

`ifndef ALU_ILLEGAL_OP_EN
  assign illegal = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Signed compare done by biasing the sign bit, then comparing unsigned.
  function automatic logic slt_m(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
  endfunction

  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c, input logic s, input logic f);
    logic [4:0] sh;
    sh = b[4:0];
    if (f) return a + b;
    case (c)
      4'd0:  return a + b;
      4'd1:  return a << sh;
      4'd2:  return {31'd0, slt_m(a, b)};
      4'd3:  return {31'd0, (a < b)};
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return s ? a - b : a + b;
      4'd13: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  // Flags packed as {eq, gteu, ltu, gtes, lts}.
  function automatic logic [4:0] model_flg(input logic [31:0] a, input logic [31:0] b);
    logic u, s;
    u = (a < b);
    s = slt_m(a, b);
    return {(a == b), !u, u, !s, s};
  endfunction

  function automatic logic model_ill(input logic [3:0] c, input logic f);
`ifdef ALU_ILLEGAL_OP_EN
    return !f && !((c <= 4'd8) || (c == 4'd13));
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input string tag, input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic s, input logic f,
                       input bit use_k, input logic [31:0] k_res);
    exp_t e;
    @(negedge clk);
    rst_l = r; a_data = a; b_data = b; ctl = c; sub_flag = s; force_add = f;
    in_valid = 1'b1;
    e.tag = tag;
    if (!r) begin
      e.res = 32'd0; e.flg = 5'd0; e.ill = 1'b0;
    end else begin
      e.res = use_k ? k_res : model_res(a, b, c, s, f);
      e.flg = model_flg(a, b);
      e.ill = model_ill(c, f);
    end
    sb_q.push_back(e);
  endtask

  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic s, input logic f);
    drive(tag, 1'b1, a, b, c, s, f, 1'b0, 32'd0);
  endtask

  task automatic send_k(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic s, input logic f, input logic [31:0] k);
    drive(tag, 1'b1, a, b, c, s, f, 1'b1, k);
  endtask

  // Monitor: each accepted input is checked one edge later.
  always begin
    exp_t e;
    @(posedge clk);
    if (in_valid) begin
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_res"}, res, e.res);
        check({e.tag, "_flg"}, {27'd0, eq, gteu, ltu, gtes, lts}, {27'd0, e.flg});
        check({e.tag, "_ill"}, {31'd0, illegal}, {31'd0, e.ill});
        $display("op %-10s a=%08h b=%08h ctl=%h res=%08h flags=%b ill=%b",
                 e.tag, a_data, b_data, ctl, res, {eq, gteu, ltu, gtes, lts}, illegal);
      end
    end
  end

  initial begin
    int budget;
    rst_l = 1'b0; a_data = '0; b_data = '0; ctl = '0; sub_flag = 1'b0; force_add = 1'b0;

    // Reset with operands that would otherwise produce nonzero outputs.
    drive("rst0", 1'b0, 32'd5, 32'd5, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    drive("rst1", 1'b0, 32'd5, 32'd5, 4'hF, 1'b1, 1'b1, 1'b0, 32'd0);
    send_k("post_rst", 32'd5, 32'd5, 4'h0, 1'b0, 1'b0, 32'h0000_000A);
    // Reset mid-stream clears outputs again.
    drive("rst_mid", 1'b0, 32'hFFFF_FFFF, 32'd1, 4'h8, 1'b1, 1'b0, 1'b0, 32'd0);

    send_k("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'h0, 1'b0, 1'b0, 32'h0000_0000);
    send_k("sub", 32'd0, 32'd1, 4'h8, 1'b1, 1'b0, 32'hFFFF_FFFF);
    send_k("addi", 32'd0, 32'd1, 4'h8, 1'b0, 1'b0, 32'h0000_0001);
    send_k("sll", 32'h8000_0001, 32'hFFFF_FFE4, 4'h1, 1'b0, 1'b0, 32'h0000_0010);
    send_k("srl", 32'h8000_0001, 32'hFFFF_FFE4, 4'h5, 1'b0, 1'b0, 32'h0800_0000);
    send_k("sra", 32'h8000_0001, 32'hFFFF_FFE4, 4'hD, 1'b0, 1'b0, 32'hF800_0000);
    send_k("sra0", 32'h8000_0001, 32'hFFFF_FFE0, 4'hD, 1'b0, 1'b0, 32'h8000_0001);
    send_k("slt", 32'h8000_0000, 32'h7FFF_FFFF, 4'h2, 1'b0, 1'b0, 32'd1);
    send_k("sltu", 32'h8000_0000, 32'h7FFF_FFFF, 4'h3, 1'b0, 1'b0, 32'd0);
    send_k("slt_m1", 32'hFFFF_FFFF, 32'h0000_0000, 4'h2, 1'b0, 1'b0, 32'd1);
    send_k("sltu_m1", 32'hFFFF_FFFF, 32'h0000_0000, 4'h3, 1'b0, 1'b0, 32'd0);
    send_k("force", 32'h10, 32'h0F, 4'h7, 1'b1, 1'b1, 32'h0000_001F);
    send_k("and", 32'h10, 32'h0F, 4'h7, 1'b0, 1'b0, 32'h0000_0000);
    send_k("xor", 32'hF0F0_1234, 32'h0FF0_FFFF, 4'h4, 1'b0, 1'b0, 32'hFF00_EDCB);
    send_k("or", 32'hF000_0001, 32'h0000_0F00, 4'h6, 1'b0, 1'b0, 32'hF000_0F01);
    send_k("illegal", 32'h1234_5678, 32'h1, 4'hF, 1'b0, 1'b0, 32'd0);
    send_k("illegal9", 32'h1234_5678, 32'h1, 4'h9, 1'b1, 1'b0, 32'd0);

    // Back-to-back random operations, one per cycle.
    for (int i = 0; i < 60; i++) begin
      send($sformatf("rnd%0d", i), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), (i % 7 == 0));
    end

    @(negedge clk);
    in_valid = 1'b0;
    budget = 0;
    while (sb_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit RV32I-style integer ALU for the CPU execute stage.
- Computes one arithmetic, logical or shift result selected by a 4-bit control code.
- In parallel, produces five operand-comparison flags for branch resolution.
- Result and flags are registered: one-cycle latency.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- SHAMT_WIDTH, 5, number of low bits of b used as shift amount; equals $clog2(DATA_WIDTH).

Ports:
- clk_w_i  in  1  clock; all state updates on the rising edge.
- rst_w_i_l  in  1  synchronous active-low reset.
- a_data_w_i  in  32  operand A (rs1).
- b_data_w_i  in  32  operand B (rs2 or immediate).
- alu_control_w_i  in  4  operation select.
- addi_sub_flag_w_i  in  1  1 = code 1000 performs SUB; 0 = code 1000 performs ADD (ADDI path).
- store_force_add_flag_w_i  in  1  1 = force A+B regardless of control (load/store address generation).
- alu_res_w_o  out  32  registered result.
- eq_w_o_h  out  1  registered A == B.
- gteu_w_o_h  out  1  registered A >= B, unsigned.
- ltu_w_o_h  out  1  registered A < B, unsigned.
- gtes_w_o_h  out  1  registered A >= B, signed.
- lts_w_o_h  out  1  registered A < B, signed.

Behaviour:
- Reset: when rst_w_i_l = 0 at a rising edge, all outputs clear to 0. Reset has priority over every input, including mid-stream operations.
- Latency: inputs sampled at edge N appear on the outputs after edge N. There is no handshake; a new operation is accepted every cycle.
- Force-add: if store_force_add_flag_w_i = 1, the result is A+B (mod 2^32). This overrides alu_control_w_i and addi_sub_flag_w_i.
- Operation decode, when force-add = 0:
  - 0000: ADD, A+B, wraps mod 2^32.
  - 0001: SLL, A << B[4:0].
  - 0010: SLT, result = 1 if signed(A) < signed(B), else 0; zero-extended to 32 bits.
  - 0011: SLTU, same as SLT but unsigned compare.
  - 0100: XOR.
  - 0101: SRL, logical right shift by B[4:0].
  - 0110: OR.
  - 0111: AND.
  - 1000: A−B if addi_sub_flag_w_i = 1, else A+B.
  - 1101: SRA, arithmetic right shift by B[4:0], sign-filled from A[31].
  - All other codes: result 0.
- Shifts ignore B[31:5]. A shift amount of 0 returns A unchanged.
- Flags are computed from A and B every cycle, independent of the control code and force-add:
  - eq = (A == B).
  - ltu = A <u B; gteu = !ltu.
  - lts = A <s B; gtes = !lts.
  - Out of reset, exactly one of each complementary pair is 1.
- Signed boundaries: 0x80000000 <s 0x7FFFFFFF; 0xFFFFFFFF <s 0x00000000; unsigned order is the opposite for both pairs.
- Sub/add overflow is silently discarded; there is no carry or overflow output.

Optional Feature:
- Macro ALU_ILLEGAL_OP_EN.
- When defined: adds output illegal_op_w_o_h (1 bit, registered, reset 0). It is 1 for a cycle when force-add = 0 and alu_control_w_i is not one of the ten legal codes. The result is still 0 in that case.
- When undefined: the port and its logic are absent; illegal codes still yield result 0.

Decomposition:
- Package alu_pkg holds:
  - localparams for the ten control codes (ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA);
  - DATA_WIDTH and SHAMT_WIDTH defaults.
- One sub-module, alu_compare: combinational eq/ltu/gteu/lts/gtes from A and B.
- The top module holds the result mux, shifters and output registers.

Test Plan:
- Reset: drive rst_w_i_l = 0 with A = 5, B = 5, control 0000 → after the edge, result = 0 and all flags = 0. Release reset → next cycle result = 0x0000000A, eq = 1, gteu = 1, gtes = 1.
- Arithmetic wrap: A = 0xFFFFFFFF, B = 1, ADD → 0x00000000. Control 1000 with addi_sub = 1 and A = 0, B = 1 → 0xFFFFFFFF. Same with addi_sub = 0 → 0x00000001.
- Shifts: A = 0x80000001, B = 0xFFFFFFE4 (shamt 4) → SLL 0x00000010, SRL 0x08000000, SRA 0xF8000000.
- Compares: A = 0x80000000, B = 0x7FFFFFFF → SLT = 1, SLTU = 0, lts = 1, gteu = 1, ltu = 0, gtes = 0, eq = 0.
- Force-add: store_force_add = 1, control 0111, A = 0x10, B = 0x0F → result 0x1F, not the AND value 0x00.
- Illegal op: control 1111, force-add = 0 → result 0; illegal_op_w_o_h = 1 when ALU_ILLEGAL_OP_EN is defined. Also run back-to-back ops every cycle and check each result one cycle later.
